qs_bank_sched: RTL and testbench

Bank scheduler for the quicksort engine. It owns the per-bank lifecycle state for the `qs_banks` memory array and hands banks to the enqueue, sort and dequeue controllers in strict ring order (fill → sort → drain). It guarantees that no two controllers ever own the same bank. It also carries each bank's valid word count from the enqueue controller to the sort and dequeue controllers.

---
 rtl/qs_bank_sched.sv | 139 +++++++++++++
 tb/tb_qs_bank_sched.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qs_bank_sched.sv
// rtl/qs_bank_sched.sv - ring-ordered bank ownership scheduler for the quicksort engine
module qs_bank_sched #(
    parameter int BANKS_N = 4,
    parameter int N       = 256,
    parameter int IDW     = $clog2(BANKS_N),
    parameter int LW      = $clog2(N) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enq_req,
    output logic                 enq_gnt_r,
    output logic [IDW-1:0]       enq_bank_idx_r,
    input  logic                 enq_done,
    input  logic [LW-1:0]        enq_len,
    input  logic                 srt_req,
    output logic                 srt_gnt_r,
    output logic [IDW-1:0]       srt_bank_idx_r,
    output logic [LW-1:0]        srt_len_r,
    input  logic                 srt_done,
    input  logic                 deq_req,
    output logic                 deq_gnt_r,
    output logic [IDW-1:0]       deq_bank_idx_r,
    output logic [LW-1:0]        deq_len_r,
    input  logic                 deq_done,
    output logic [3*BANKS_N-1:0] bank_status_r,
    output logic                 all_idle_r,
    output logic                 err_r
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ENQ    = 3'd1,
        ST_READY  = 3'd2,
        ST_SORT   = 3'd3,
        ST_SORTED = 3'd4,
        ST_DEQ    = 3'd5
    } bank_st_e;

    bank_st_e             bank_st [BANKS_N];
    bank_st_e             st_nxt  [BANKS_N];
    logic [LW-1:0]        len     [BANKS_N];
    logic [IDW-1:0]       enq_ptr, srt_ptr, deq_ptr;

    logic                 enq_grant, srt_grant, deq_grant;
    logic                 enq_acc, srt_acc, deq_acc;
    logic                 enq_over;
    logic [LW-1:0]        enq_len_sat;
    logic [3*BANKS_N-1:0] status_nxt;
    logic                 all_idle_nxt;
    logic                 err_nxt;

    // Each transition requires a distinct current state, so all of them can
    // land on the same edge without ever colliding on one bank.
    always_comb begin
        enq_grant    = !enq_gnt_r && enq_req && (bank_st[enq_ptr] == ST_IDLE);
        srt_grant    = !srt_gnt_r && srt_req && (bank_st[srt_ptr] == ST_READY);
        deq_grant    = !deq_gnt_r && deq_req && (bank_st[deq_ptr] == ST_SORTED);
        enq_acc      = enq_done && enq_gnt_r;
        srt_acc      = srt_done && srt_gnt_r;
        deq_acc      = deq_done && deq_gnt_r;
        enq_over     = enq_len > LW'(N);
        enq_len_sat  = enq_over ? LW'(N) : enq_len;
        err_nxt      = err_r
                     || (enq_done && (!enq_gnt_r || enq_over))
                     || (srt_done && !srt_gnt_r)
                     || (deq_done && !deq_gnt_r);

        st_nxt = bank_st;
        if (enq_grant) st_nxt[enq_ptr]        = ST_ENQ;
        if (enq_acc)   st_nxt[enq_bank_idx_r] = ST_READY;
        if (srt_grant) st_nxt[srt_ptr]        = ST_SORT;
        if (srt_acc)   st_nxt[srt_bank_idx_r] = ST_SORTED;
        if (deq_grant) st_nxt[deq_ptr]        = ST_DEQ;
        if (deq_acc)   st_nxt[deq_bank_idx_r] = ST_IDLE;

        status_nxt   = '0;
        all_idle_nxt = 1'b1;
        for (int i = 0; i < BANKS_N; i++) begin
            status_nxt[3*i +: 3] = st_nxt[i];
            if (st_nxt[i] != ST_IDLE) all_idle_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BANKS_N; i++) begin
                bank_st[i] <= ST_IDLE;
                len[i]     <= '0;
            end
            enq_ptr        <= '0;
            srt_ptr        <= '0;
            deq_ptr        <= '0;
            enq_gnt_r      <= 1'b0;
            srt_gnt_r      <= 1'b0;
            deq_gnt_r      <= 1'b0;
            enq_bank_idx_r <= '0;
            srt_bank_idx_r <= '0;
            deq_bank_idx_r <= '0;
            srt_len_r      <= '0;
            deq_len_r      <= '0;
            bank_status_r  <= '0;
            all_idle_r     <= 1'b1;
            err_r          <= 1'b0;
        end else begin
            bank_st       <= st_nxt;
            bank_status_r <= status_nxt;
            all_idle_r    <= all_idle_nxt;
            err_r         <= err_nxt;

            if (enq_grant) begin
                enq_gnt_r      <= 1'b1;
                enq_bank_idx_r <= enq_ptr;
            end else if (enq_acc) begin
                enq_gnt_r           <= 1'b0;
                enq_ptr             <= enq_ptr + IDW'(1);
                len[enq_bank_idx_r] <= enq_len_sat;
            end

            if (srt_grant) begin
                srt_gnt_r      <= 1'b1;
                srt_bank_idx_r <= srt_ptr;
                srt_len_r      <= len[srt_ptr];
            end else if (srt_acc) begin
                srt_gnt_r <= 1'b0;
                srt_ptr   <= srt_ptr + IDW'(1);
            end

            if (deq_grant) begin
                deq_gnt_r      <= 1'b1;
                deq_bank_idx_r <= deq_ptr;
                deq_len_r      <= len[deq_ptr];
            end else if (deq_acc) begin
                deq_gnt_r <= 1'b0;
                deq_ptr   <= deq_ptr + IDW'(1);
            end
        end
    end

endmodule

// File: tb/tb_qs_bank_sched.sv
// tb/tb_qs_bank_sched.sv - self-checking bench for qs_bank_sched
module tb_qs_bank_sched;

    logic        clk = 1'b0;
    logic        rst, enq_req, enq_done, srt_req, srt_done, deq_req, deq_done;
    logic [8:0]  enq_len;
    logic        enq_gnt_r, srt_gnt_r, deq_gnt_r, all_idle_r, err_r;
    logic [1:0]  enq_bank_idx_r, srt_bank_idx_r, deq_bank_idx_r;
    logic [8:0]  srt_len_r, deq_len_r;
    logic [11:0] bank_status_r;

    int n_chk = 0;
    int n_err = 0;

    qs_bank_sched dut (
        .clk(clk), .rst(rst),
        .enq_req(enq_req), .enq_gnt_r(enq_gnt_r), .enq_bank_idx_r(enq_bank_idx_r),
        .enq_done(enq_done), .enq_len(enq_len),
        .srt_req(srt_req), .srt_gnt_r(srt_gnt_r), .srt_bank_idx_r(srt_bank_idx_r),
        .srt_len_r(srt_len_r), .srt_done(srt_done),
        .deq_req(deq_req), .deq_gnt_r(deq_gnt_r), .deq_bank_idx_r(deq_bank_idx_r),
        .deq_len_r(deq_len_r), .deq_done(deq_done),
        .bank_status_r(bank_status_r), .all_idle_r(all_idle_r), .err_r(err_r)
    );

    always #5 clk = ~clk;

    // Reference model: bank lifecycle as plain integers (0 idle .. 5 drain).
    int ms[4];
    int ml[4];
    int ep, sp, dp;
    int meg, msg, mdg, mei, msi, mdi, msl, mdl, merr;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            ms[i] = 0;
            ml[i] = 0;
        end
        ep = 0; sp = 0; dp = 0;
        meg = 0; msg = 0; mdg = 0;
        mei = 0; msi = 0; mdi = 0;
        msl = 0; mdl = 0; merr = 0;
    endtask

    task automatic model_edge();
        int eg, sg, dg;
        if (rst) begin
            model_reset();
            return;
        end
        eg = (meg == 0 && enq_req && ms[ep] == 0) ? 1 : 0;
        sg = (msg == 0 && srt_req && ms[sp] == 2) ? 1 : 0;
        dg = (mdg == 0 && deq_req && ms[dp] == 4) ? 1 : 0;
        if (enq_done) begin
            if (meg != 0) begin
                if (int'(enq_len) > 256) begin
                    ml[mei] = 256;
                    merr = 1;
                end else begin
                    ml[mei] = int'(enq_len);
                end
                ms[mei] = 2; ep = (ep + 1) % 4; meg = 0;
            end else merr = 1;
        end
        if (srt_done) begin
            if (msg != 0) begin
                ms[msi] = 4; sp = (sp + 1) % 4; msg = 0;
            end else merr = 1;
        end
        if (deq_done) begin
            if (mdg != 0) begin
                ms[mdi] = 0; dp = (dp + 1) % 4; mdg = 0;
            end else merr = 1;
        end
        if (eg != 0) begin
            ms[ep] = 1; meg = 1; mei = ep;
        end
        if (sg != 0) begin
            ms[sp] = 3; msg = 1; msi = sp; msl = ml[sp];
        end
        if (dg != 0) begin
            ms[dp] = 5; mdg = 1; mdi = dp; mdl = ml[dp];
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        logic [11:0] st;
        int idle;
        @(posedge clk);
        model_edge();
        #1;
        st = '0;
        idle = 1;
        for (int i = 0; i < 4; i++) begin
            st[3*i +: 3] = 3'(ms[i]);
            if (ms[i] != 0) idle = 0;
        end
        check("status", 32'(bank_status_r), 32'(st));
        check("all_idle", 32'(all_idle_r), 32'(idle));
        check("err", 32'(err_r), 32'(merr));
        check("enq_gnt", 32'(enq_gnt_r), 32'(meg));
        check("srt_gnt", 32'(srt_gnt_r), 32'(msg));
        check("deq_gnt", 32'(deq_gnt_r), 32'(mdg));
        check("enq_idx", 32'(enq_bank_idx_r), 32'(mei));
        check("srt_idx", 32'(srt_bank_idx_r), 32'(msi));
        check("deq_idx", 32'(deq_bank_idx_r), 32'(mdi));
        check("srt_len", 32'(srt_len_r), 32'(msl));
        check("deq_len", 32'(deq_len_r), 32'(mdl));
    endtask

    // ctl bits: {rst, enq_req, enq_done, srt_req, srt_done, deq_req, deq_done}
    task automatic drive(input logic [6:0] ctl, input logic [8:0] el);
        {rst, enq_req, enq_done, srt_req, srt_done, deq_req, deq_done} = ctl;
        enq_len = el;
    endtask

    task automatic step(input logic [6:0] ctl, input logic [8:0] el);
        drive(ctl, el);
        cycle();
    endtask

    typedef struct packed {
        logic [6:0]  ctl;
        logic [8:0]  el;
        logic [11:0] st;
        logic [2:0]  gnt;
        logic [8:0]  sl;
        logic [8:0]  dl;
        logic        er;
    } vec_t;

    vec_t vecs[19];

    initial begin
        vecs[0]  = '{7'b1000000, 9'd0,   12'h000, 3'b000, 9'd0,   9'd0, 1'b0};
        vecs[1]  = '{7'b0100000, 9'd0,   12'h001, 3'b100, 9'd0,   9'd0, 1'b0};
        vecs[2]  = '{7'b0010000, 9'd5,   12'h002, 3'b000, 9'd0,   9'd0, 1'b0};
        vecs[3]  = '{7'b0001000, 9'd0,   12'h003, 3'b010, 9'd5,   9'd0, 1'b0};
        vecs[4]  = '{7'b0000100, 9'd0,   12'h004, 3'b000, 9'd5,   9'd0, 1'b0};
        vecs[5]  = '{7'b0000010, 9'd0,   12'h005, 3'b001, 9'd5,   9'd5, 1'b0};
        vecs[6]  = '{7'b0000001, 9'd0,   12'h000, 3'b000, 9'd5,   9'd5, 1'b0};
        vecs[7]  = '{7'b0100000, 9'd0,   12'h008, 3'b100, 9'd5,   9'd5, 1'b0};
        vecs[8]  = '{7'b0010000, 9'd300, 12'h010, 3'b000, 9'd5,   9'd5, 1'b1};
        vecs[9]  = '{7'b0001000, 9'd0,   12'h018, 3'b010, 9'd256, 9'd5, 1'b1};
        vecs[10] = '{7'b0000100, 9'd0,   12'h020, 3'b000, 9'd256, 9'd5, 1'b1};
        vecs[11] = '{7'b0000100, 9'd0,   12'h020, 3'b000, 9'd256, 9'd5, 1'b1};
        vecs[12] = '{7'b1000000, 9'd0,   12'h000, 3'b000, 9'd0,   9'd0, 1'b0};
        vecs[13] = '{7'b0100000, 9'd0,   12'h001, 3'b100, 9'd0,   9'd0, 1'b0};
        vecs[14] = '{7'b0010000, 9'd0,   12'h002, 3'b000, 9'd0,   9'd0, 1'b0};
        vecs[15] = '{7'b0001000, 9'd0,   12'h003, 3'b010, 9'd0,   9'd0, 1'b0};
        vecs[16] = '{7'b0000100, 9'd0,   12'h004, 3'b000, 9'd0,   9'd0, 1'b0};
        vecs[17] = '{7'b0000010, 9'd0,   12'h005, 3'b001, 9'd0,   9'd0, 1'b0};
        vecs[18] = '{7'b0000001, 9'd0,   12'h000, 3'b000, 9'd0,   9'd0, 1'b0};

        model_reset();
        drive(7'b1000000, 9'd0);
        repeat (2) @(posedge clk);
        #1;

        // Single bank pass, error pulse, clamp and zero-length flow
        for (int i = 0; i < 19; i++) begin
            step(vecs[i].ctl, vecs[i].el);
            check("tbl_status", 32'(bank_status_r), 32'(vecs[i].st));
            check("tbl_gnt", 32'({enq_gnt_r, srt_gnt_r, deq_gnt_r}), 32'(vecs[i].gnt));
            check("tbl_srt_len", 32'(srt_len_r), 32'(vecs[i].sl));
            check("tbl_deq_len", 32'(deq_len_r), 32'(vecs[i].dl));
            check("tbl_err", 32'(err_r), 32'(vecs[i].er));
        end

        // Full and wrap
        step(7'b1000000, 9'd0);
        for (int i = 0; i < 4; i++) begin
            step(7'b0100000, 9'd0);
            step(7'b0010000, 9'(i + 1));
        end
        for (int i = 0; i < 20; i++) begin
            step(7'b0100000, 9'd0);
            check("full_stall", 32'(enq_gnt_r), 32'd0);
        end
        step(7'b0101000, 9'd0);
        check("wrap_srt_len0", 32'(srt_len_r), 32'd1);
        step(7'b0100100, 9'd0);
        step(7'b0100010, 9'd0);
        check("wrap_deq_len0", 32'(deq_len_r), 32'd1);
        step(7'b0100001, 9'd0);
        check("wrap_gnt_after_done", 32'(enq_gnt_r), 32'd0);
        step(7'b0100000, 9'd0);
        check("wrap_enq_gnt", 32'(enq_gnt_r), 32'd1);
        check("wrap_enq_idx", 32'(enq_bank_idx_r), 32'd0);
        for (int k = 1; k < 4; k++) begin
            step(7'b0001000, 9'd0);
            check("order_srt_idx", 32'(srt_bank_idx_r), 32'(k));
            check("order_srt_len", 32'(srt_len_r), 32'(k + 1));
            step(7'b0000100, 9'd0);
            step(7'b0000010, 9'd0);
            check("order_deq_idx", 32'(deq_bank_idx_r), 32'(k));
            check("order_deq_len", 32'(deq_len_r), 32'(k + 1));
            step(7'b0000001, 9'd0);
        end

        // Concurrency: enq owns 2, sort owns 1, deq owns 0, all done together
        step(7'b1000000, 9'd0);
        step(7'b0100000, 9'd0);
        step(7'b0010000, 9'd7);
        step(7'b0100000, 9'd0);
        step(7'b0010000, 9'd8);
        step(7'b0100000, 9'd0);
        step(7'b0001000, 9'd0);
        step(7'b0000100, 9'd0);
        step(7'b0000010, 9'd0);
        step(7'b0001000, 9'd0);
        check("conc_pre", 32'(bank_status_r), 32'h05D);
        step(7'b0010101, 9'd9);
        check("conc_status", 32'(bank_status_r), 32'h0A0);
        check("conc_gnts", 32'({enq_gnt_r, srt_gnt_r, deq_gnt_r}), 32'd0);
        check("conc_err", 32'(err_r), 32'd0);

        // Reset mid-run with bank1 in SORT and bank2 in ENQ
        step(7'b1000000, 9'd0);
        step(7'b0100000, 9'd0);
        step(7'b0010000, 9'd3);
        step(7'b0100000, 9'd0);
        step(7'b0010000, 9'd4);
        step(7'b0001000, 9'd0);
        step(7'b0000100, 9'd0);
        step(7'b0000010, 9'd0);
        step(7'b0000001, 9'd0);
        step(7'b0101000, 9'd0);
        check("mid_status", 32'(bank_status_r), 32'h058);
        step(7'b1000000, 9'd0);
        check("rst_status", 32'(bank_status_r), 32'd0);
        check("rst_idle", 32'(all_idle_r), 32'd1);
        check("rst_gnts", 32'({enq_gnt_r, srt_gnt_r, deq_gnt_r}), 32'd0);
        check("rst_lens", 32'({srt_len_r, deq_len_r}), 32'd0);
        step(7'b0100000, 9'd0);
        check("post_rst_gnt", 32'(enq_gnt_r), 32'd1);
        check("post_rst_idx", 32'(enq_bank_idx_r), 32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 299) == 0);
            enq_req  = 1'($urandom_range(0, 1));
            srt_req  = 1'($urandom_range(0, 1));
            deq_req  = 1'($urandom_range(0, 1));
            enq_done = (meg != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
            srt_done = (msg != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
            deq_done = (mdg != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
            enq_len  = ($urandom_range(0, 30) == 0) ? 9'($urandom_range(257, 300))
                                                    : 9'($urandom_range(0, 256));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
